// File: rtl/cpu_trap_ctrl_pkg.sv
// cpu_trap_ctrl_pkg: exception/interrupt cause codes, mtvec modes and trap FSM encodings
package cpu_trap_ctrl_pkg;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam int ISA_EXP_NO_EXP           = 0;
    localparam int ISA_EXP_ILLEGAL          = 1;
    localparam int ISA_EXP_LOAD_MISALIGNED  = 2;
    localparam int ISA_EXP_STORE_MISALIGNED = 3;
    localparam int ISA_EXP_OVERFLOW         = 4;
    localparam logic [4:0] MCAUSE_ILLEGAL_INST     = 5'd2;
    localparam logic [4:0] MCAUSE_BREAKPOINT       = 5'd3;
    localparam logic [4:0] MCAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] MCAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] MCAUSE_ECALL_M          = 5'd11;
    localparam logic [4:0] MCAUSE_OVERFLOW         = 5'd24;
    localparam logic [4:0] MCAUSE_MSI              = 5'd3;
    localparam logic [4:0] MCAUSE_MTI              = 5'd7;
    localparam logic [4:0] MCAUSE_MEI              = 5'd11;
    localparam logic [4:0] MCAUSE_LOCAL_BASE       = 5'd16;
    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    typedef struct packed {
        logic       is_mret;
        logic       is_irq;
        logic [4:0] code;
    } trap_kind_t;
    function automatic logic tval_valid(input logic is_irq, input logic [4:0] code);
        return !is_irq && (code == MCAUSE_ILLEGAL_INST || code == MCAUSE_LOAD_MISALIGNED ||
                           code == MCAUSE_STORE_MISALIGNED);
    endfunction
endpackage

// File: rtl/cpu_trap_ctrl_irq_sync.sv
// cpu_irq_sync: multi-flop synchroniser with level or sticky rising-edge pending output
module cpu_irq_sync
    import cpu_trap_ctrl_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic EDGE        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw_i,
    input  logic clear_i,
    output logic pending_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q;
    logic                   rise;
    assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign pending_o = EDGE ? pend_q : sync_q[SYNC_STAGES-1];
    // synchronise the raw line; a fresh edge outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= DISABLE;
            pend_q <= DISABLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= rise | (pend_q & ~clear_i);
        end
endmodule

// File: rtl/cpu_trap_ctrl.sv
// cpu_trap_ctrl: arbitrates exceptions, interrupts and mret into registered one-cycle commit pulses
module cpu_trap_ctrl
    import cpu_trap_ctrl_pkg::*;
#(
    parameter int                       PC_WIDTH       = 32,
    parameter int                       NUM_LOCAL_IRQ  = 4,
    parameter logic [NUM_LOCAL_IRQ-1:0] LOCAL_IRQ_EDGE = '0,
    parameter int                       SYNC_STAGES    = 2,
    parameter int                       EXP_WIDTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_valid,
    input  logic [PC_WIDTH-1:0]         mem_pc,
    input  logic [EXP_WIDTH-1:0]        mem_exp_code,
    input  logic                        mem_ecall_en,
    input  logic                        mem_ebreak_en,
    input  logic                        mem_mret_en,
    input  logic [31:0]                 mem_tval,
    input  logic                        ahb_bus_wait,
    input  logic                        ext_irq_raw,
    input  logic                        timer_irq_raw,
    input  logic                        soft_irq_raw,
    input  logic [NUM_LOCAL_IRQ-1:0]    local_irq_raw,
    input  logic                        csr_mstatus_mie,
    input  logic [16+NUM_LOCAL_IRQ-1:0] csr_mie,
    input  logic [29:0]                 csr_mtvec_base,
    input  logic [1:0]                  csr_mtvec_mode,
    input  logic [PC_WIDTH-1:0]         csr_mepc_pc,
    output logic [16+NUM_LOCAL_IRQ-1:0] irq_pending,
    output logic                        trap_commit,
    output logic                        mret_commit,
    output logic [PC_WIDTH-1:0]         mepc_set_pc,
    output logic [31:0]                 mcause_set_cause,
    output logic [31:0]                 mtval_set_tval,
    output logic                        redirect_en,
    output logic [PC_WIDTH-1:0]         ctrl_pc,
    output logic                        pipe_flush,
    output logic                        pipe_hold,
    output logic                        busy
);
    localparam int NI = 16 + NUM_LOCAL_IRQ;
    logic [1:0]               state_q, state_d;
    trap_kind_t               live, cap_q, sel;
    logic [PC_WIDTH-1:0]      cap_pc_q, sel_pc, trap_pc;
    logic [31:0]              cap_tval_q, live_tval, sel_tval;
    logic                     exc, irq, req, go_commit;
    logic [4:0]               exc_code, irq_code;
    logic [NI-1:0]            irq_act;
    logic                     ext_pend, timer_pend, soft_pend;
    logic [NUM_LOCAL_IRQ-1:0] local_pend, local_clr;
    cpu_irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_ext (
        .clk(clk), .rst_n(rst_n), .irq_raw_i(ext_irq_raw), .clear_i(DISABLE), .pending_o(ext_pend));
    cpu_irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_timer (
        .clk(clk), .rst_n(rst_n), .irq_raw_i(timer_irq_raw), .clear_i(DISABLE), .pending_o(timer_pend));
    cpu_irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_soft (
        .clk(clk), .rst_n(rst_n), .irq_raw_i(soft_irq_raw), .clear_i(DISABLE), .pending_o(soft_pend));
    for (genvar i = 0; i < NUM_LOCAL_IRQ; i++) begin : g_local
        assign local_clr[i] = go_commit && sel.is_irq && sel.code == MCAUSE_LOCAL_BASE + 5'(i);
        cpu_irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(LOCAL_IRQ_EDGE[i])) u_sync (
            .clk(clk), .rst_n(rst_n), .irq_raw_i(local_irq_raw[i]), .clear_i(local_clr[i]),
            .pending_o(local_pend[i]));
    end
    assign busy      = state_q != ST_IDLE;
    assign pipe_hold = busy;
    // place synchronised lines at their mcause bit positions
    always_comb begin
        irq_pending              = '0;
        irq_pending[MCAUSE_MSI]  = soft_pend;
        irq_pending[MCAUSE_MTI]  = timer_pend;
        irq_pending[MCAUSE_MEI]  = ext_pend;
        irq_pending[NI-1:16]     = local_pend;
    end
    // request detection and priority arbitration; WAIT/COMMIT work from the captured request
    always_comb begin
        exc       = mem_valid && (mem_exp_code != EXP_WIDTH'(ISA_EXP_NO_EXP) || mem_ecall_en || mem_ebreak_en);
        irq_act   = irq_pending & csr_mie;
        irq       = mem_valid && csr_mstatus_mie && |irq_act;
        exc_code  = mem_ecall_en ? MCAUSE_ECALL_M :
                    mem_ebreak_en ? MCAUSE_BREAKPOINT :
                    mem_exp_code == EXP_WIDTH'(ISA_EXP_LOAD_MISALIGNED) ? MCAUSE_LOAD_MISALIGNED :
                    mem_exp_code == EXP_WIDTH'(ISA_EXP_STORE_MISALIGNED) ? MCAUSE_STORE_MISALIGNED :
                    mem_exp_code == EXP_WIDTH'(ISA_EXP_OVERFLOW) ? MCAUSE_OVERFLOW : MCAUSE_ILLEGAL_INST;
        irq_code  = '0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++)
            if (irq_act[16+i]) irq_code = MCAUSE_LOCAL_BASE + 5'(i);
        if (irq_act[MCAUSE_MTI]) irq_code = MCAUSE_MTI;
        if (irq_act[MCAUSE_MSI]) irq_code = MCAUSE_MSI;
        if (irq_act[MCAUSE_MEI]) irq_code = MCAUSE_MEI;
        live.is_irq  = !exc && irq;
        live.is_mret = !exc && !irq && mem_valid && mem_mret_en;
        live.code    = exc ? exc_code : irq ? irq_code : '0;
        live_tval    = tval_valid(live.is_irq, live.code) ? mem_tval : '0;
        req          = exc || irq || live.is_mret;
        sel          = state_q == ST_IDLE ? live : cap_q;
        sel_pc       = state_q == ST_IDLE ? mem_pc : cap_pc_q;
        sel_tval     = state_q == ST_IDLE ? live_tval : cap_tval_q;
        trap_pc      = PC_WIDTH'({csr_mtvec_base, 2'b00}) +
                       ((csr_mtvec_mode == MTVEC_MODE_VECTORED && sel.is_irq) ? PC_WIDTH'({sel.code, 2'b00}) : '0);
        state_d      = state_q == ST_IDLE ? (req ? (ahb_bus_wait ? ST_WAIT : ST_COMMIT) : ST_IDLE) :
                       state_q == ST_WAIT ? (ahb_bus_wait ? ST_WAIT : ST_COMMIT) : ST_IDLE;
        go_commit    = state_d == ST_COMMIT;
    end
    // capture the winning request in IDLE so later interrupts cannot alter it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cap_q      <= '0;
            cap_pc_q   <= '0;
            cap_tval_q <= '0;
        end else if (state_q == ST_IDLE && req) begin
            cap_q      <= live;
            cap_pc_q   <= mem_pc;
            cap_tval_q <= live_tval;
        end
    // FSM state and registered one-cycle commit outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            trap_commit      <= DISABLE;
            mret_commit      <= DISABLE;
            redirect_en      <= DISABLE;
            pipe_flush       <= DISABLE;
            mepc_set_pc      <= '0;
            mcause_set_cause <= '0;
            mtval_set_tval   <= '0;
            ctrl_pc          <= '0;
        end else begin
            state_q          <= state_d;
            trap_commit      <= go_commit && !sel.is_mret;
            mret_commit      <= go_commit && sel.is_mret;
            redirect_en      <= go_commit;
            pipe_flush       <= go_commit;
            mepc_set_pc      <= go_commit && !sel.is_mret ? sel_pc : '0;
            mcause_set_cause <= go_commit && !sel.is_mret ? {sel.is_irq, 26'd0, sel.code} : '0;
            mtval_set_tval   <= go_commit && !sel.is_mret ? sel_tval : '0;
            ctrl_pc          <= !go_commit ? '0 : sel.is_mret ? csr_mepc_pc : trap_pc;
        end
endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// tb_cpu_trap_ctrl: directed stimulus checked every cycle against a behavioural trap model
module tb_cpu_trap_ctrl;
    import cpu_trap_ctrl_pkg::*;
    localparam int PW = 32, NL = 4, S = 2, NI = 16 + NL;
    localparam logic [NL-1:0] EDGE = 4'b0100;
    logic clk = 0, rst_n = 0;
    logic mem_valid = 0, mem_ecall_en = 0, mem_ebreak_en = 0, mem_mret_en = 0, ahb_bus_wait = 0;
    logic [PW-1:0] mem_pc = '0, csr_mepc_pc = '0;
    logic [3:0] mem_exp_code = '0;
    logic [31:0] mem_tval = '0;
    logic ext_irq_raw = 0, timer_irq_raw = 0, soft_irq_raw = 0, csr_mstatus_mie = 0;
    logic [NL-1:0] local_irq_raw = '0;
    logic [NI-1:0] csr_mie = '0;
    logic [29:0] csr_mtvec_base = 30'h800;
    logic [1:0] csr_mtvec_mode = 2'd0;
    logic [NI-1:0] irq_pending;
    logic trap_commit, mret_commit, redirect_en, pipe_flush, pipe_hold, busy;
    logic [PW-1:0] mepc_set_pc, ctrl_pc;
    logic [31:0] mcause_set_cause, mtval_set_tval;
    cpu_trap_ctrl #(.PC_WIDTH(PW), .NUM_LOCAL_IRQ(NL), .LOCAL_IRQ_EDGE(EDGE), .SYNC_STAGES(S), .EXP_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
        .mem_ecall_en(mem_ecall_en), .mem_ebreak_en(mem_ebreak_en), .mem_mret_en(mem_mret_en),
        .mem_tval(mem_tval), .ahb_bus_wait(ahb_bus_wait), .ext_irq_raw(ext_irq_raw),
        .timer_irq_raw(timer_irq_raw), .soft_irq_raw(soft_irq_raw), .local_irq_raw(local_irq_raw),
        .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie), .csr_mtvec_base(csr_mtvec_base),
        .csr_mtvec_mode(csr_mtvec_mode), .csr_mepc_pc(csr_mepc_pc), .irq_pending(irq_pending),
        .trap_commit(trap_commit), .mret_commit(mret_commit), .mepc_set_pc(mepc_set_pc),
        .mcause_set_cause(mcause_set_cause), .mtval_set_tval(mtval_set_tval), .redirect_en(redirect_en),
        .ctrl_pc(ctrl_pc), .pipe_flush(pipe_flush), .pipe_hold(pipe_hold), .busy(busy));
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // ---------------- behavioural model ----------------
    logic [NI-1:0] hist [0:S];
    logic [NI-1:0] m_edge;
    int phase;
    bit r_irq, r_mret;
    int r_code;
    logic [31:0] r_pc, r_tval;
    logic e_trap, e_mret;
    logic [31:0] e_mepc, e_cause, e_tval, e_pc;
    function automatic logic [NI-1:0] emask();
        return NI'(EDGE) << 16;
    endfunction
    function automatic logic [NI-1:0] raw_vec();
        logic [NI-1:0] v = '0;
        v[3] = soft_irq_raw; v[7] = timer_irq_raw; v[11] = ext_irq_raw;
        for (int i = 0; i < NL; i++) v[16+i] = local_irq_raw[i];
        return v;
    endfunction
    function automatic logic [NI-1:0] model_pend();
        return (hist[S-1] & ~emask()) | (m_edge & emask());
    endfunction
    function automatic int exp_cause(input logic [3:0] c);
        case (c)
            4'd2: return 4;
            4'd3: return 6;
            4'd4: return 24;
            default: return 2;
        endcase
    endfunction
    task automatic model_reset();
        for (int k = 0; k <= S; k++) hist[k] = '0;
        m_edge = '0; phase = 0;
        e_trap = 0; e_mret = 0; e_mepc = 0; e_cause = 0; e_tval = 0; e_pc = 0;
    endtask
    task automatic find_request(input logic [NI-1:0] pend, output bit found);
        logic [NI-1:0] act = pend & csr_mie;
        int order [3+NL];
        found = 1; r_pc = mem_pc; r_tval = 0; r_irq = 0; r_mret = 0; r_code = 0;
        order[0] = 11; order[1] = 3; order[2] = 7;
        for (int i = 0; i < NL; i++) order[3+i] = 16 + NL - 1 - i;
        if (mem_valid && (mem_exp_code != 0 || mem_ecall_en || mem_ebreak_en)) begin
            r_code = mem_ecall_en ? 11 : mem_ebreak_en ? 3 : exp_cause(mem_exp_code);
            if (r_code == 2 || r_code == 4 || r_code == 6) r_tval = mem_tval;
        end else if (mem_valid && csr_mstatus_mie && act != 0) begin
            bit got = 0;
            r_irq = 1;
            for (int k = 0; k < 3 + NL; k++)
                if (!got && act[order[k]]) begin r_code = order[k]; got = 1; end
        end else if (mem_valid && mem_mret_en) r_mret = 1;
        else found = 0;
    endtask
    task automatic do_commit(inout logic [NI-1:0] clr);
        phase = 2;
        if (r_mret) begin
            e_mret = 1; e_pc = csr_mepc_pc;
        end else begin
            e_trap = 1; e_mepc = r_pc; e_cause = {r_irq, 31'(r_code)}; e_tval = r_tval;
            e_pc = {csr_mtvec_base, 2'b00} + ((csr_mtvec_mode == 2'd1 && r_irq) ? 32'(r_code * 4) : 0);
            if (r_irq) clr[r_code] = 1'b1;
        end
    endtask
    task automatic model_step();
        logic [NI-1:0] pend = model_pend();
        logic [NI-1:0] rise = hist[S-1] & ~hist[S];
        logic [NI-1:0] clr = '0;
        bit found;
        e_trap = 0; e_mret = 0; e_mepc = 0; e_cause = 0; e_tval = 0; e_pc = 0;
        if (phase == 2) phase = 0;
        else if (phase == 1) begin
            if (!ahb_bus_wait) do_commit(clr);
        end else begin
            find_request(pend, found);
            if (found) begin
                if (ahb_bus_wait) phase = 1;
                else do_commit(clr);
            end
        end
        m_edge = (rise | (m_edge & ~clr)) & emask();
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw_vec();
    endtask
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end
    initial forever begin
        @(negedge clk);
        check("pending", irq_pending, model_pend());
        check("trap_commit", trap_commit, e_trap);
        check("mret_commit", mret_commit, e_mret);
        check("mepc", mepc_set_pc, e_mepc);
        check("mcause", mcause_set_cause, e_cause);
        check("mtval", mtval_set_tval, e_tval);
        check("redirect", redirect_en, e_trap | e_mret);
        check("flush", pipe_flush, e_trap | e_mret);
        check("ctrl_pc", ctrl_pc, e_pc);
        check("busy", busy, phase != 0);
        check("hold", pipe_hold, phase != 0);
    end
    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic clear_req();
        mem_valid = 0; mem_ecall_en = 0; mem_ebreak_en = 0; mem_mret_en = 0; mem_exp_code = 0;
    endtask
    initial begin
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_pend", irq_pending, 0);
        check("rst_ctrl_pc", ctrl_pc, 0);
        rst_n = 1;
        tick();
        // 1: ecall, DIRECT mtvec 0x2000
        mem_valid = 1; mem_ecall_en = 1; mem_pc = 32'h100;
        tick();
        check("t1_trap", trap_commit, 1);
        check("t1_cause", mcause_set_cause, 32'h0000000B);
        check("t1_mepc", mepc_set_pc, 32'h100);
        check("t1_pc", ctrl_pc, 32'h2000);
        check("t1_flush", pipe_flush, 1);
        clear_req(); tick();
        // 2: edge pulse on local line 2, VECTORED
        csr_mstatus_mie = 1; csr_mie = 20'h40000; csr_mtvec_mode = 2'd1;
        local_irq_raw[2] = 1; tick();
        local_irq_raw[2] = 0; tick();
        check("t2_pend_early", irq_pending[18], 0);
        tick();
        check("t2_pend_set", irq_pending[18], 1);
        mem_valid = 1; mem_pc = 32'h200;
        tick();
        check("t2_trap", trap_commit, 1);
        check("t2_cause", mcause_set_cause, 32'h80000012);
        check("t2_pc", ctrl_pc, 32'h2048);
        check("t2_pend_clr", irq_pending[18], 0);
        clear_req(); csr_mstatus_mie = 0; csr_mtvec_mode = 2'd0; tick();
        // 3: illegal instruction held off by the bus; MEI arrives during WAIT
        mem_valid = 1; mem_exp_code = ISA_EXP_ILLEGAL; mem_tval = 32'hDEADBEEF; mem_pc = 32'h300; ahb_bus_wait = 1;
        tick();
        check("t3_hold1", pipe_hold, 1);
        clear_req(); ext_irq_raw = 1; csr_mstatus_mie = 1; csr_mie = 20'h00800;
        tick(); check("t3_hold2", pipe_hold, 1);
        tick(); check("t3_hold3", pipe_hold, 1);
        check("t3_notyet", trap_commit, 0);
        ahb_bus_wait = 0;
        tick();
        check("t3_trap", trap_commit, 1);
        check("t3_cause", mcause_set_cause, 32'h2);
        check("t3_tval", mtval_set_tval, 32'hDEADBEEF);
        check("t3_mepc", mepc_set_pc, 32'h300);
        ext_irq_raw = 0; csr_mstatus_mie = 0;
        repeat (3) tick();
        // 4: store misaligned and MEI together; MEI taken after mret re-enables MIE
        ext_irq_raw = 1; csr_mstatus_mie = 1;
        repeat (2) tick();
        check("t4_pend", irq_pending[11], 1);
        mem_valid = 1; mem_exp_code = ISA_EXP_STORE_MISALIGNED; mem_tval = 32'h1234; mem_pc = 32'h500;
        tick();
        check("t4_cause_exc", mcause_set_cause, 32'h6);
        check("t4_tval", mtval_set_tval, 32'h1234);
        clear_req(); csr_mstatus_mie = 0; tick();
        mem_valid = 1; mem_mret_en = 1; csr_mepc_pc = 32'h500;
        tick();
        check("t4_mret", mret_commit, 1);
        check("t4_mret_pc", ctrl_pc, 32'h500);
        clear_req(); csr_mstatus_mie = 1; tick();
        mem_valid = 1; mem_pc = 32'h500;
        tick();
        check("t4_cause_irq", mcause_set_cause, 32'h8000000B);
        check("t4_irq_pc", ctrl_pc, 32'h2000);
        check("t4_irq_tval", mtval_set_tval, 0);
        clear_req(); ext_irq_raw = 0; csr_mstatus_mie = 0;
        repeat (3) tick();
        // 5: mret through one WAIT cycle
        mem_valid = 1; mem_mret_en = 1; csr_mepc_pc = 32'h340; ahb_bus_wait = 1;
        tick();
        check("t5_wait", busy, 1);
        clear_req(); ahb_bus_wait = 0;
        tick();
        check("t5_mret", mret_commit, 1);
        check("t5_pc", ctrl_pc, 32'h340);
        check("t5_notrap", trap_commit, 0);
        tick();
        // exception priority and tval rules, VECTORED must not offset exceptions
        csr_mtvec_mode = 2'd1;
        mem_valid = 1; mem_ebreak_en = 1; mem_tval = 32'h99; mem_pc = 32'h600;
        tick();
        check("ebreak_cause", mcause_set_cause, 32'h3);
        check("ebreak_pc", ctrl_pc, 32'h2000);
        check("ebreak_tval", mtval_set_tval, 0);
        clear_req(); tick();
        mem_valid = 1; mem_ecall_en = 1; mem_ebreak_en = 1; mem_exp_code = ISA_EXP_ILLEGAL;
        tick();
        check("ecall_prio", mcause_set_cause, 32'hB);
        check("ecall_tval", mtval_set_tval, 0);
        clear_req(); tick();
        mem_valid = 1; mem_exp_code = ISA_EXP_OVERFLOW;
        tick();
        check("ovf_cause", mcause_set_cause, 32'h18);
        check("ovf_tval", mtval_set_tval, 0);
        clear_req(); csr_mtvec_mode = 2'd0; tick();
        // 6: reset while in WAIT
        ext_irq_raw = 1;
        repeat (3) tick();
        mem_valid = 1; mem_ebreak_en = 1; ahb_bus_wait = 1;
        tick();
        check("t6_wait", busy, 1);
        rst_n = 0; #1;
        check("t6_busy", busy, 0);
        check("t6_hold", pipe_hold, 0);
        check("t6_pend", irq_pending, 0);
        check("t6_trap", trap_commit, 0);
        clear_req(); ahb_bus_wait = 0; ext_irq_raw = 0;
        tick();
        rst_n = 1;
        repeat (4) tick();
        check("t6_no_commit", trap_commit, 0);
        check("t6_idle", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_trap_ctrl.md
Name: cpu_trap_ctrl

Overview:
Parametrised trap and interrupt sequencer for the siiCpu core, sitting beside the MEM stage. It synchronises and latches machine interrupts plus NUM_LOCAL_IRQ platform interrupt lines, each configurable as edge or level. It arbitrates exceptions, interrupts and mret with a small FSM, and issues one-cycle registered commit pulses to the CSR file, the PC and the pipeline flush/stall network. Trap entry is deferred while the AHB bus is busy.

Parameters:
PC_WIDTH, 32, program counter width
NUM_LOCAL_IRQ, 4, local interrupt lines (1..16); mcause code is 16+i
LOCAL_IRQ_EDGE, 4'b0000, per-line mode: 1 = rising-edge latched, 0 = level
SYNC_STAGES, 2, synchroniser flops on every raw interrupt input (>=2)
EXP_WIDTH, 4, exception code width (matches ISA_EXP_* codes)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  MEM stage holds a real instruction
mem_pc  in  PC_WIDTH  PC of the MEM instruction
mem_exp_code  in  EXP_WIDTH  MEM exception code; ISA_EXP_NO_EXP = none
mem_ecall_en / mem_ebreak_en / mem_mret_en  in  1 each  system instruction in MEM
mem_tval  in  32  faulting address/instruction for mtval
ahb_bus_wait  in  1  bus transfer outstanding
ext_irq_raw / timer_irq_raw / soft_irq_raw  in  1 each  asynchronous machine interrupt lines
local_irq_raw  in  NUM_LOCAL_IRQ  asynchronous local lines
csr_mstatus_mie  in  1  global interrupt enable
csr_mie  in  16+NUM_LOCAL_IRQ  per-cause enables (bit = mcause code)
csr_mtvec_base  in  30  trap base; csr_mtvec_mode  in  2  DIRECT/VECTORED
csr_mepc_pc  in  PC_WIDTH  mret target
irq_pending  out  16+NUM_LOCAL_IRQ  pending bits to mip (bits 3, 7, 11, 16+i)
trap_commit  out  1  pulse: write mepc/mcause/mtval, clear MIE, set MPIE
mret_commit  out  1  pulse: restore MIE from MPIE
mepc_set_pc  out  PC_WIDTH; mcause_set_cause  out  32; mtval_set_tval  out  32
redirect_en  out  1; ctrl_pc  out  PC_WIDTH  PC redirect (same cycle as commit)
pipe_flush  out  1  flush IF..MEM (same cycle as commit)
pipe_hold  out  1  stall PC..MEM while FSM is not IDLE
busy  out  1  FSM not IDLE

Behaviour:
- Reset: FSM IDLE; all outputs 0; synchronisers and pending latches cleared. Reset mid-WAIT aborts with no commit.
- Sync: every raw line passes SYNC_STAGES flops. Edge lines set a sticky pending bit on a synced 0->1 transition. That bit clears only in the cycle its trap commits; a new edge in that same cycle wins, so the bit stays set. Level lines: pending = synced level. Machine ext/timer/soft lines are level.
- Request (combinational, evaluated in IDLE only):
  - exception = mem_valid && (exp_code != NO_EXP || ecall || ebreak);
  - interrupt = mem_valid && mstatus_mie && |(irq_pending & csr_mie);
  - mret = mem_valid && mem_mret_en && !exception.
- Priority:
  - exception > interrupt > mret.
  - Exception codes: ecall(11) > ebreak(3) > illegal(2) > load-misaligned(4) > store-misaligned(6) > overflow(24).
  - Interrupts: MEI(11) > MSI(3) > MTI(7) > local highest index first.
- FSM IDLE:
  - any request with ahb_bus_wait=1 -> WAIT, capturing kind, cause, pc and tval into registers;
  - with ahb_bus_wait=0 -> COMMIT.
- WAIT: pipe_hold=1; captured values frozen; leaves for COMMIT in the first cycle ahb_bus_wait=0. Interrupts arriving during WAIT do not change the captured cause.
- COMMIT (exactly one cycle), outputs registered from the captured values:
  - trap: trap_commit=1, redirect_en=1, pipe_flush=1; mepc = captured pc; mcause = {interrupt, 31-bit code}; mtval = tval for misaligned/illegal, else 0;
  - ctrl_pc = {base,2'b00}, plus code<<2 only when VECTORED and the trap is an interrupt;
  - mret: mret_commit=1, redirect_en=1, pipe_flush=1, ctrl_pc = csr_mepc_pc;
  - next state IDLE. Request evaluation is suppressed in COMMIT, so back-to-back traps are separated by at least one IDLE cycle.
- Latency: request in IDLE with bus idle -> commit pulse on the next clock edge.
- mepc for interrupts = mem_pc; the MEM instruction is killed and re-executed.

Decomposition:
- Shared define package: ISA_EXP_* codes, MCAUSE_* codes (add MCAUSE_LOCAL_BASE=16), MTVEC_MODE_*, FSM state encodings, ENABLE/DISABLE.
- One sub-module: cpu_irq_sync (SYNC_STAGES synchroniser plus edge/level pending latch per line), instantiated per line via generate.

Test Plan:
1. mem_valid=1, mem_ecall_en=1, mem_pc=0x100, mtvec=0x2000 DIRECT, bus idle -> next cycle trap_commit=1, mcause=0x0000000B, mepc=0x100, ctrl_pc=0x2000, pipe_flush=1.
2. MIE=1, csr_mie[18]=1, edge pulse on local_irq_raw[2], VECTORED base 0x2000 -> pending[18] set after SYNC_STAGES+1 cycles; commit mcause=0x80000012, ctrl_pc=0x2048; pending[18] cleared.
3. Illegal instruction with ahb_bus_wait held 3 cycles -> WAIT with pipe_hold=1 for 3 cycles; commit on the cycle after the wait drops, mcause=2, mtval=mem_tval.
4. Exception and MEI in the same cycle -> exception committed first; MEI committed after MIE is re-enabled by a later mret.
5. mem_mret_en=1, csr_mepc_pc=0x340 -> mret_commit=1, ctrl_pc=0x340, trap_commit=0.
6. Assert rst_n=0 while in WAIT -> all outputs 0 immediately; no commit after release; pending bits cleared.
